// File: rtl/onehot_scan_decoder_if.sv
// Handshake-free bundle between a scan controller and the one-hot scan decoder.
// master drives enable/mode/binary and observes the decode; slave is the decoder side.
interface onehot_scan_decoder_if #(
  parameter int WIDTH = 2
);
  localparam int OUTS = 1 << WIDTH;

  logic             en_L;
  logic [1:0]       mode;
  logic [WIDTH-1:0] binary;
  logic [OUTS-1:0]  onehot;
  logic [WIDTH-1:0] index;
  logic             wrap;

  modport master (output en_L, mode, binary, input onehot, index, wrap);
  modport slave  (input en_L, mode, binary, output onehot, index, wrap);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered index with load / scan-up / scan-down every DIV clocks; combinational gated one-hot decode.
// Load and steps show one edge later, en_L blanking is immediate; no backpressure, every edge is accepted.
module onehot_scan_decoder #(
  parameter int WIDTH = 2,
  parameter int DIV   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  onehot_scan_decoder_if.slave  bus
);
  localparam int OUTS = 1 << WIDTH;
  localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(DIV - 1);
  localparam logic [WIDTH-1:0] IDX_MAX   = '1;

  logic [TW-1:0]    tick;
  logic [WIDTH-1:0] index_q;
  logic             wrap_q;
  logic             step;

  // With DIV == 1 the tick register never leaves 0, so every scan edge is a step.
  assign step = (tick == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick    <= '0;
      index_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (bus.mode)
        2'b01: begin
          index_q <= bus.binary;
          tick    <= '0;
        end
        2'b10, 2'b11: begin
          if (step) begin
            tick <= '0;
            if (bus.mode[0]) begin
              index_q <= index_q - WIDTH'(1);
              wrap_q  <= (index_q == '0);
            end else begin
              index_q <= index_q + WIDTH'(1);
              wrap_q  <= (index_q == IDX_MAX);
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.index  = index_q;
  assign bus.wrap   = wrap_q;
  assign bus.onehot = bus.en_L ? '0 : (OUTS'(1) << index_q);
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboarded bench: one stimulus stream drives a DIV=3 and a DIV=1 decoder, each checked
// against its own arithmetic reference model through an expectation queue.
module tb_onehot_scan_decoder;
  logic       clock = 1'b0;
  logic       reset;
  logic       en_L;
  logic [1:0] mode;
  logic [1:0] binary;

  always #5 clock = ~clock;

  onehot_scan_decoder_if #(.WIDTH(2)) bus3 ();
  onehot_scan_decoder_if #(.WIDTH(2)) bus1 ();

  assign bus3.en_L   = en_L;
  assign bus3.mode   = mode;
  assign bus3.binary = binary;
  assign bus1.en_L   = en_L;
  assign bus1.mode   = mode;
  assign bus1.binary = binary;

  onehot_scan_decoder #(.WIDTH(2), .DIV(3)) u_div3 (.clock(clock), .reset(reset), .bus(bus3.slave));
  onehot_scan_decoder #(.WIDTH(2), .DIV(1)) u_div1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  typedef struct {
    int idx;
    int oh;
    int wr;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_idx[2];
  int   m_tick[2];
  int   m_wrap[2];
  int   divs[2] = '{3, 1};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k]  = 0;
      m_tick[k] = 0;
      m_wrap[k] = 0;
    end
  endfunction

  // Effect of one rising edge on the scanner, from the scan rules with plain arithmetic.
  function automatic void model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      if (mode == 2'b01) begin
        m_idx[k]  = int'(binary);
        m_tick[k] = 0;
      end else if (mode[1]) begin
        if (m_tick[k] + 1 >= divs[k]) begin
          m_tick[k] = 0;
          if (mode == 2'b10) begin
            m_wrap[k] = (m_idx[k] == 3) ? 1 : 0;
            m_idx[k]  = (m_idx[k] + 1) % 4;
          end else begin
            m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
            m_idx[k]  = (m_idx[k] + 3) % 4;
          end
        end else begin
          m_tick[k] = m_tick[k] + 1;
        end
      end
    end
  endfunction

  function automatic exp_t expect_of(input int k);
    exp_t e;
    e.idx = m_idx[k];
    e.oh  = en_L ? 0 : (1 << m_idx[k]);
    e.wr  = m_wrap[k];
    return e;
  endfunction

  task automatic step(input logic r, input logic en, input logic [1:0] m, input logic [1:0] b);
    @(negedge clock);
    reset  = r;
    en_L   = en;
    mode   = m;
    binary = b;
    model_edge();
    q3.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  // Monitor: each edge the decoders present a new state; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check("div3_index",  int'(bus3.index),  e.idx);
        check("div3_onehot", int'(bus3.onehot), e.oh);
        check("div3_wrap",   int'(bus3.wrap),   e.wr);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("div1_index",  int'(bus1.index),  e.idx);
        check("div1_onehot", int'(bus1.onehot), e.oh);
        check("div1_wrap",   int'(bus1.wrap),   e.wr);
      end
    end
  end

  initial begin
    logic       r;
    logic       en;
    logic [1:0] m;
    logic [1:0] b;

    reset  = 1'b1;
    en_L   = 1'b0;
    mode   = 2'b00;
    binary = 2'b00;
    model_reset();
    #2;
    check("rst_index",  int'(bus3.index),  0);
    check("rst_onehot", int'(bus3.onehot), 1);
    check("rst_wrap",   int'(bus3.wrap),   0);
    check("rst_onehot_div1", int'(bus1.onehot), 1);
    en_L = 1'b1;
    #1;
    check("blank_onehot", int'(bus3.onehot), 0);
    check("blank_index",  int'(bus3.index),  0);
    en_L = 1'b0;

    step(1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 2'b00, 2'b00);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b01, 2'(i));

    // Scan up from 2 through the wrap to 0.
    step(1'b0, 1'b0, 2'b01, 2'd2);
    repeat (7) step(1'b0, 1'b0, 2'b10, 2'($urandom));

    // Scan down from 1; the DIV=1 instance steps every edge.
    step(1'b0, 1'b0, 2'b01, 2'd1);
    repeat (6) step(1'b0, 1'b0, 2'b11, 2'($urandom));

    // Hold preserves tick, then direction change.
    step(1'b0, 1'b0, 2'b01, 2'd0);
    repeat (2) step(1'b0, 1'b0, 2'b10, 2'($urandom));
    repeat (5) step(1'b0, 1'b0, 2'b00, 2'($urandom));
    repeat (3) step(1'b0, 1'b0, 2'b11, 2'($urandom));

    // Blanking between edges leaves the index untouched.
    @(posedge clock);
    #3;
    en_L = 1'b1;
    #1;
    check("midcycle_blank_onehot", int'(bus3.onehot), 0);
    check("midcycle_blank_index",  int'(bus3.index),  m_idx[0]);

    // Async reset while index=3, tick=1.
    step(1'b0, 1'b0, 2'b01, 2'd3);
    step(1'b0, 1'b0, 2'b10, 2'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_index",  int'(bus3.index),  0);
    check("async_rst_onehot", int'(bus3.onehot), 1);
    check("async_rst_wrap",   int'(bus3.wrap),   0);
    model_reset();
    repeat (4) step(1'b0, 1'b0, 2'b10, 2'($urandom));

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) == 0);
      m  = 2'($urandom);
      b  = 2'($urandom);
      step(r, en, m, b);
    end
    step(1'b0, 1'b0, 2'b10, 2'b00);

    repeat (3) @(posedge clock);
    #2;
    check("queues_drained", q3.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
